// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO frame controller.
//   state_t   : frame FSM state, 1-bit encoded (IDLE / SHIFT)
//   cnt_width : bit-counter width able to hold 0..width-1
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Never returns 0, so the counter always has at least one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// WIDTH-bit serial-in shift register, MSB first.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-low reset, clears the register
//   en  : shift enable (a valid serial bit this cycle)
//   si  : serial input bit
//   q   : current register contents
module sipo_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr <= '0;
    end else if (en) begin
      r_sr <= {r_sr[WIDTH-2:0], si};
    end
  end

  assign q = r_sr;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller for a serial-in parallel-out link: aligns on sync,
// counts WIDTH bits per frame and hands completed frames to a one-deep
// valid/ready holding register, flagging dropped frames with overrun.
// Ports:
//   clk, rst          : clock and synchronous active-low reset
//   si, si_valid      : serial bit (MSB first) and its qualifier
//   sync              : marks si as the first bit of a new frame
//   out_data/out_valid: completed frame and its valid flag
//   out_ready         : consumer accepts the held frame
//   busy              : a frame is partially received
//   overrun           : one-cycle pulse when a completed frame is dropped
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned     CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_complete;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0] w_word;
  logic             w_unused_msb;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;

  // Shift path runs on every valid bit; only bits after a sync are counted.
  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk (clk),
    .rst (rst),
    .en  (si_valid),
    .si  (si),
    .q   (w_sr)
  );

  // The oldest bit falls off when the last bit of a frame shifts in.
  assign w_word       = {w_sr[WIDTH-2:0], si};
  assign w_unused_msb = w_sr[WIDTH-1];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (si_valid && sync) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (si_valid && !sync && (r_cnt == LAST)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter and frame-completion decode; a sync always restarts at bit 1.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        if (si_valid && sync) w_cnt_nxt = CNT_W'(1);
      end
      SHIFT: begin
        if (si_valid) begin
          if (sync) begin
            w_cnt_nxt = CNT_W'(1);
          end else if (r_cnt == LAST) begin
            w_cnt_nxt  = '0;
            w_complete = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  // A frame lands if the slot is empty or being emptied this same cycle.
  assign w_load = w_complete && (!r_valid || out_ready);
  assign w_drop = w_complete && r_valid && !out_ready;

  // Counter, holding register and overrun flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovr <= w_drop;
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign overrun   = r_ovr;
  assign busy      = (r_state == SHIFT);

endmodule
